// File: rtl/wbc_arb2.sv
// -----------------------------------------------------------------------------
// wbc_arb2 - two-master Wishbone arbiter for the shared 16-bit block-RAM slave.
//
// Master 0 (CPU) and master 1 (loader / DMA) share one single-port memory.
// Arbitration is round-robin. The granted master keeps ownership for as long
// as its cyc stays high. A per-transfer timeout turns a missing slave ack
// into an err pulse for the owner.
//
// Parameters
//   TMO    cycles a granted strobe may wait for s_ack_i before err (2..255)
//   TMO_W  timeout counter width, TMO < 2**TMO_W
//
// Ports
//   wb_clk_i, wb_rst_n          clock, asynchronous active-low reset
//   mX_cyc_i/stb_i/we_i         master X Wishbone controls
//   mX_sel_i, mX_adr_i, mX_dat_i byte selects, address, write data
//   mX_dat_o                    read data (always s_dat_i)
//   mX_ack_o, mX_err_o          master X termination
//   s_cyc_o ... s_dat_o         muxed request to the memory slave
//   s_dat_i, s_ack_i            memory slave response
//   gnt_o                       one-hot current owner, 00 when idle
// -----------------------------------------------------------------------------
module wbc_arb2 #(
    parameter int TMO   = 64,
    parameter int TMO_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_sel_i,
    input  logic [15:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_sel_i,
    input  logic [15:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [1:0]  s_sel_o,
    output logic [15:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic             last, last_nxt;     // master granted most recently
    logic [TMO_W-1:0] tcnt, tcnt_nxt;

    logic req0, req1;
    logic stb_mux;                        // granted master's strobe before timeout masking
    logic tc;
    logic tmo_hit;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    // Read data is broadcast; only ack/err qualify who may use it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Request mux towards the slave.
    always_comb begin
        gnt_o   = 2'b00;
        s_cyc_o = 1'b0;
        stb_mux = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        unique case (state)
            G0: begin
                gnt_o   = 2'b01;
                s_cyc_o = m0_cyc_i;
                stb_mux = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            G1: begin
                gnt_o   = 2'b10;
                s_cyc_o = m1_cyc_i;
                stb_mux = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: ;
        endcase
    end

    // A late ack on the terminal cycle still wins over the timeout.
    assign tc      = (tcnt == TMO_W'(TMO - 1));
    assign tmo_hit = stb_mux & tc & ~s_ack_i;

    // Drop the strobe on the timeout cycle so the slave abandons the transfer.
    assign s_stb_o = stb_mux & ~tmo_hit;

    assign m0_ack_o = gnt_o[0] & m0_stb_i & s_ack_i;
    assign m1_ack_o = gnt_o[1] & m1_stb_i & s_ack_i;
    assign m0_err_o = gnt_o[0] & m0_stb_i & tmo_hit;
    assign m1_err_o = gnt_o[1] & m1_stb_i & tmo_hit;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        tcnt_nxt  = tcnt;
        unique case (state)
            IDLE: begin
                tcnt_nxt = '0;
                // On a tie the master not granted last wins.
                if (req0 && (!req1 || last)) begin
                    state_nxt = G0;
                    last_nxt  = 1'b0;
                end else if (req1) begin
                    state_nxt = G1;
                    last_nxt  = 1'b1;
                end
            end
            G0, G1: begin
                if (s_ack_i || !stb_mux || tmo_hit)
                    tcnt_nxt = '0;
                else
                    tcnt_nxt = tcnt + TMO_W'(1);
                // Always pass through IDLE so the slave's read pipeline drains
                // before a different master can be granted.
                if ((state == G0) ? !m0_cyc_i : !m1_cyc_i)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
